// File: rtl/fxp_mac_accumulator.sv
// fxp_mac_accumulator: streaming signed fixed-point MAC with bias add and output saturation
module fxp_mac_accumulator #(
    parameter int BITSIZE = 20,
    parameter int FRAC    = 10,
    parameter int GUARD   = 4,
    parameter int CNTW    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [BITSIZE-1:0] in_x,
    input  logic signed [BITSIZE-1:0] in_w,
    input  logic                      in_last,
    input  logic signed [BITSIZE-1:0] in_bias,
    output logic                      out_valid,
    output logic signed [BITSIZE-1:0] out_data,
    output logic                      out_sat,
    output logic        [CNTW-1:0]    out_beats
);
    localparam int PW   = 2 * BITSIZE;
    localparam int ACCW = 2 * BITSIZE - FRAC + GUARD;
    localparam logic signed [BITSIZE-1:0] DMAX = {1'b0, {(BITSIZE-1){1'b1}}};
    localparam logic signed [BITSIZE-1:0] DMIN = {1'b1, {(BITSIZE-1){1'b0}}};
    localparam logic signed [ACCW:0]      RMAX = (ACCW+1)'(DMAX);
    localparam logic signed [ACCW:0]      RMIN = (ACCW+1)'(DMIN);

    logic signed [PW-1:0]      p1_q, p1_d;
    logic                      v1_q, v1_d, l1_q, l1_d;
    logic signed [BITSIZE-1:0] bias1_q, bias1_d, bias2_q, bias2_d;
    logic signed [ACCW-1:0]    acc_q, acc_d, s;
    logic        [CNTW-1:0]    cnt_q, cnt_d, beats_q, beats_d;
    logic                      first_q, first_d, done2_q, done2_d;
    logic                      valid_q, valid_d, sat_q, sat_d;
    logic signed [BITSIZE-1:0] data_q, data_d;
    logic signed [ACCW:0]      r;
    logic                      hi, lo;

    // next-state for the multiply, accumulate and bias/saturate stages
    always_comb begin
        p1_d    = in_valid ? PW'(in_x) * PW'(in_w) : p1_q;
        v1_d    = in_valid;
        l1_d    = in_valid & in_last;
        bias1_d = (in_valid & in_last) ? in_bias : bias1_q;
        s       = ACCW'(p1_q >>> FRAC);
        acc_d   = v1_q ? (first_q ? s : acc_q + s) : acc_q;
        cnt_d   = v1_q ? (first_q ? CNTW'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1)) : cnt_q;
        first_d = v1_q ? l1_q : first_q;
        done2_d = v1_q & l1_q;
        bias2_d = (v1_q & l1_q) ? bias1_q : bias2_q;
        r       = (ACCW+1)'(acc_q) + (ACCW+1)'(bias2_q);
        hi      = r > RMAX;
        lo      = r < RMIN;
        valid_d = done2_q;
        data_d  = done2_q ? (hi ? DMAX : lo ? DMIN : r[BITSIZE-1:0]) : data_q;
        sat_d   = done2_q ? (hi | lo) : sat_q;
        beats_d = done2_q ? cnt_q : beats_q;
    end

    // pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_q    <= '0;
            v1_q    <= 1'b0;
            l1_q    <= 1'b0;
            bias1_q <= '0;
            bias2_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            done2_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            beats_q <= '0;
        end else begin
            p1_q    <= p1_d;
            v1_q    <= v1_d;
            l1_q    <= l1_d;
            bias1_q <= bias1_d;
            bias2_q <= bias2_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            done2_q <= done2_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            beats_q <= beats_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sat   = sat_q;
    assign out_beats = beats_q;
endmodule

// File: tb/tb_fxp_mac_accumulator.sv
// tb_fxp_mac_accumulator: directed vector bench for the fixed-point MAC accumulator
module tb_fxp_mac_accumulator;
    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [19:0] in_x, in_w, in_bias;
    logic               in_last;
    logic               out_valid;
    logic signed [19:0] out_data;
    logic               out_sat;
    logic        [7:0]  out_beats;

    typedef struct {
        logic signed [19:0] x;
        logic signed [19:0] w;
        logic signed [19:0] bias;
        logic signed [19:0] exp_data;
        logic               exp_sat;
    } vec_t;

    typedef struct {
        logic signed [19:0] d;
        logic               s;
        logic        [7:0]  b;
        int                 e;
    } pulse_t;

    pulse_t pq[$];
    int     edges = 0;
    int     tests = 0;
    int     fails = 0;
    vec_t   tbl[10];

    fxp_mac_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_w(in_w),
        .in_last(in_last), .in_bias(in_bias), .out_valid(out_valid),
        .out_data(out_data), .out_sat(out_sat), .out_beats(out_beats)
    );

    always #5 clk = ~clk;

    // count rising edges so pulse latency can be measured
    always @(posedge clk) edges <= edges + 1;

    // capture every output pulse away from the active edge
    always @(negedge clk) if (out_valid) pq.push_back('{out_data, out_sat, out_beats, edges});

    task automatic chk(input string n, input longint a, input longint e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", n, a, e);
        end
    endtask

    task automatic beat(input logic signed [19:0] x, input logic signed [19:0] w,
                        input logic l, input logic signed [19:0] b, output int e);
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        in_last  = l;
        in_bias  = b;
        @(negedge clk);
        e = edges;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input string n, input longint d, input logic s,
                                input longint b, input int e);
        pulse_t p;
        if (pq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got no pulse, expected one at edge %0d", n, e + 2);
        end else begin
            p = pq.pop_front();
            chk({n, ".data"}, p.d, d);
            chk({n, ".sat"}, p.s, s);
            chk({n, ".beats"}, p.b, b);
            chk({n, ".edge"}, p.e, e + 2);
        end
    endtask

    task automatic expect_none(input string n);
        chk({n, ".no_pulse"}, pq.size(), 0);
        pq.delete();
    endtask

    initial begin
        int e, d;
        tbl[0] = '{20'sd2048,    20'sd1536,  20'sd256,     20'sd3328,    1'b0};
        tbl[1] = '{20'sd1,       20'sd512,   20'sd0,       20'sd0,       1'b0};
        tbl[2] = '{-20'sd1,      20'sd512,   20'sd0,       -20'sd1,      1'b0};
        tbl[3] = '{20'sd1024,    20'sd1024,  20'sd523263,  20'sd524287,  1'b0};
        tbl[4] = '{20'sd1024,    20'sd1024,  20'sd523264,  20'sd524287,  1'b1};
        tbl[5] = '{-20'sd1024,   20'sd1024,  -20'sd523264, -20'sd524288, 1'b0};
        tbl[6] = '{-20'sd1024,   20'sd1024,  -20'sd523265, -20'sd524288, 1'b1};
        tbl[7] = '{20'sd409600,  20'sd2048,  20'sd0,       20'sd524287,  1'b1};
        tbl[8] = '{-20'sd409600, 20'sd2048,  20'sd0,       -20'sd524288, 1'b1};
        tbl[9] = '{-20'sd3,      -20'sd341,  20'sd100,     20'sd100,     1'b0};
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_x = '0;
        in_w = '0;
        in_bias = '0;
        repeat (3) @(negedge clk);
        chk("reset.valid", out_valid, 0);
        chk("reset.data", out_data, 0);
        chk("reset.sat", out_sat, 0);
        chk("reset.beats", out_beats, 0);
        rst = 1'b0;
        idle(2);
        for (int i = 0; i < 10; i++) begin
            beat(tbl[i].x, tbl[i].w, 1'b1, tbl[i].bias, e);
            idle(1);
            chk($sformatf("vec%0d.early", i), pq.size(), 0);
            idle(4);
            expect_pulse($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_sat, 1, e);
            expect_none($sformatf("vec%0d", i));
        end
        beat(20'sd1024, 20'sd1024, 1'b0, 20'sd0, e);
        beat(20'sd1024, 20'sd1024, 1'b0, 20'sd0, e);
        idle(1);
        beat(20'sd1024, 20'sd1024, 1'b0, 20'sd0, e);
        idle(2);
        expect_none("gaps.before_last");
        beat(20'sd1024, 20'sd1024, 1'b1, -20'sd1024, e);
        idle(5);
        expect_pulse("gaps", 3072, 1'b0, 4, e);
        expect_none("gaps");
        beat(20'sd409600, 20'sd2048, 1'b0, 20'sd0, e);
        beat(20'sd409600, 20'sd2048, 1'b1, 20'sd0, e);
        idle(5);
        expect_pulse("satpos2", 524287, 1'b1, 2, e);
        beat(-20'sd409600, 20'sd2048, 1'b0, 20'sd0, e);
        beat(-20'sd409600, 20'sd2048, 1'b1, 20'sd0, e);
        idle(5);
        expect_pulse("satneg2", -524288, 1'b1, 2, e);
        expect_none("sat2");
        beat(20'sd3072, 20'sd2048, 1'b1, 20'sd0, e);
        beat(20'sd1024, 20'sd512, 1'b0, 20'sd999, d);
        beat(20'sd1024, 20'sd512, 1'b1, 20'sd0, d);
        beat(-20'sd512, 20'sd1024, 1'b1, 20'sd0, d);
        idle(6);
        expect_pulse("b2b.g1", 6144, 1'b0, 1, e);
        expect_pulse("b2b.g2", 1024, 1'b0, 2, e + 2);
        expect_pulse("b2b.g3", -512, 1'b0, 1, d);
        expect_none("b2b");
        in_valid = 1'b0;
        in_last = 1'b1;
        in_bias = 20'sd77;
        repeat (5) @(negedge clk);
        expect_none("last_without_valid");
        beat(20'sd1024, 20'sd1024, 1'b0, 20'sd0, e);
        beat(20'sd1024, 20'sd1024, 1'b0, 20'sd0, e);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset.data", out_data, 0);
        chk("midreset.beats", out_beats, 0);
        idle(5);
        expect_none("midreset");
        beat(20'sd1024, 20'sd1024, 1'b1, 20'sd0, e);
        idle(5);
        expect_pulse("after_reset", 1024, 1'b0, 1, e);
        expect_none("after_reset");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
